// File: rtl/irq_exc_controller.sv
// irq_exc_controller
//   Sequences entry into and exit from the kernel handlers of the pipelined
//   MIPS CPU. It watches the timer interrupt and the ID-stage undefined-
//   instruction flag. At a safe pipeline point it redirects the PC to a
//   vector, squashes IF/ID and writes the return address into $k0. It then
//   tracks kernel mode until the handler returns with jr $k0.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   irq_in       timer interrupt request (level or pulse)
//   undef_inst   ID instruction is undefined
//   id_valid     ID holds a real instruction
//   id_pc        PC of the ID instruction
//   id_ctrl      ID instruction is a branch/jump/jr/jal
//   ex_redirect  EX is redirecting the PC this cycle
//   stall        hazard unit is stalling IF/ID
//   isr_ret      jr $k0 resolved in EX while in kernel mode
//   vec_valid    override next PC with vec_pc (one-cycle pulse)
//   vec_pc       IRQ_VEC or EXC_VEC
//   flush_if_id  squash IF and ID (one-cycle pulse)
//   k0_we        write $k0 (one-cycle pulse)
//   k0_data      return address written to $k0
//   kernel       kernel-mode flag
//   irq_pending  sticky interrupt request not yet serviced
//   irq_count    number of interrupts taken (wraps)
module irq_exc_controller #(
    parameter logic [31:0] IRQ_VEC = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC = 32'h8000_0008,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    input  logic             undef_inst,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic             id_ctrl,
    input  logic             ex_redirect,
    input  logic             stall,
    input  logic             isr_ret,
    output logic             vec_valid,
    output logic [31:0]      vec_pc,
    output logic             flush_if_id,
    output logic             k0_we,
    output logic [31:0]      k0_data,
    output logic             kernel,
    output logic             irq_pending,
    output logic [CNT_W-1:0] irq_count
);

    typedef enum logic [1:0] {
        USER   = 2'd0,
        WAIT   = 2'd1,
        KERNEL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic             safe, take_exc, take_irq, req;

    assign kernel      = (state_q == KERNEL);
    assign irq_pending = pend_q;
    assign irq_count   = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= USER;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (take_irq)
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        vec_valid   = 1'b0;
        vec_pc      = 32'h0;
        flush_if_id = 1'b0;
        k0_we       = 1'b0;
        k0_data     = 32'h0;
        state_d     = state_q;
        pend_d      = pend_q;

        // id_pc is only the true next-to-execute PC when nothing older is
        // about to redirect and ID itself is not a control transfer.
        safe     = id_valid & ~stall & ~id_ctrl & ~ex_redirect;
        req      = pend_q | irq_in;
        take_exc = ~reset & undef_inst & id_valid & ~stall;
        take_irq = ~reset & ~take_exc & req & safe & ~kernel;

        if (take_exc) begin
            vec_valid   = 1'b1;
            vec_pc      = EXC_VEC;
            flush_if_id = 1'b1;
            k0_we       = 1'b1;
            k0_data     = id_pc + 32'd4;
        end else if (take_irq) begin
            // The flushed instruction is re-executed on return.
            vec_valid   = 1'b1;
            vec_pc      = IRQ_VEC;
            flush_if_id = 1'b1;
            k0_we       = 1'b1;
            k0_data     = id_pc;
        end

        // A request coinciding with the return is kept so it can be taken
        // right after kernel mode drops.
        if (take_irq)
            pend_d = 1'b0;
        else if (irq_in & (~kernel | isr_ret))
            pend_d = 1'b1;

        case (state_q)
            USER: begin
                if (take_exc | take_irq) state_d = KERNEL;
                else if (req)            state_d = WAIT;
            end
            WAIT: begin
                if (take_exc | take_irq) state_d = KERNEL;
                else if (!req)           state_d = USER;
            end
            KERNEL: begin
                if (take_exc)     state_d = KERNEL;
                else if (isr_ret) state_d = USER;
            end
            default: state_d = USER;
        endcase
    end

endmodule

// File: doc/irq_exc_controller.md
Name: irq_exc_controller

Overview:
- Sequences entry into and exit from the kernel handlers of the pipelined MIPS CPU.
- Watches the timer interrupt line and the ID-stage illegal-instruction flag, and picks a safe pipeline point to act.
- At that point it redirects the PC to the interrupt or exception vector, flushes IF/ID, and writes the return address into $k0.
- Tracks kernel mode (PC[31]) until the handler returns with jr $k0.

Parameters:
- IRQ_VEC, 32'h80000004, interrupt handler entry (ROM word 1).
- EXC_VEC, 32'h80000008, exception handler entry (ROM word 2).
- CNT_W, 16, width of the taken-interrupt counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- irq_in  in  1  timer interrupt request (TCON-derived; level or pulse)
- undef_inst  in  1  ID-stage instruction is undefined
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_pc  in  32  PC of the ID-stage instruction
- id_ctrl  in  1  ID instruction is a branch/jump/jr/jal
- ex_redirect  in  1  EX is redirecting the PC this cycle (taken branch/jr)
- stall  in  1  hazard unit is stalling IF/ID
- isr_ret  in  1  jr $k0 resolved in EX while kernel=1
- vec_valid  out  1  override the next PC with vec_pc
- vec_pc  out  32  IRQ_VEC or EXC_VEC
- flush_if_id  out  1  squash the IF and ID instructions
- k0_we  out  1  write $k0 (reg 26)
- k0_data  out  32  return address
- kernel  out  1  kernel-mode flag
- irq_pending  out  1  sticky request not yet serviced
- irq_count  out  CNT_W  number of interrupts taken

Behaviour:
- Reset (clk edge with reset=1): state=USER, kernel=0, irq_pending=0, irq_count=0. All pulse outputs are 0 and k0_data=0.
- States:
  - USER: normal execution.
  - WAIT: interrupt pending but no safe point yet.
  - KERNEL: inside a handler.
- Pending latch:
  - irq_pending is set on any cycle with irq_in=1 while kernel=0.
  - It is cleared in the cycle the interrupt is taken.
  - irq_in while kernel=1 is ignored; a level request is seen again after return.
- Safe point: safe = id_valid & ~stall & ~id_ctrl & ~ex_redirect. This guarantees id_pc is the correct next-to-execute instruction.
- Taking (combinational in cycle n; state register updates at edge n+1):
  - take_exc = undef_inst & id_valid & ~stall. Allowed in any state, including KERNEL.
  - take_irq = ~take_exc & (irq_pending | irq_in) & safe & ~kernel.
- On take in cycle n: vec_valid=1, flush_if_id=1, k0_we=1, all for exactly one cycle.
  - take_irq: vec_pc=IRQ_VEC, k0_data=id_pc. The flushed instruction is re-executed on return.
  - take_exc: vec_pc=EXC_VEC, k0_data=id_pc+4 (mod 2^32).
- Exception has priority over interrupt in the same cycle.
- Transitions:
  - USER→WAIT: pending and not safe.
  - USER/WAIT→KERNEL: on any take. kernel=1 from n+1.
  - irq_count increments on take_irq only and wraps at 2^CNT_W.
- KERNEL→USER on isr_ret. kernel=0 from the next cycle.
- If isr_ret and irq_in coincide: the return wins, the request is latched, and the interrupt can be taken from cycle n+1 onward.
- When not taking, all outputs other than kernel, irq_pending and irq_count are 0.
- Reset mid-WAIT or mid-KERNEL returns to USER immediately and discards the pending request.

Test Plan:
- Reset for 2 cycles -> kernel=0, irq_pending=0, irq_count=0, vec_valid=0.
- USER, id_pc=0x00000068, safe, 1-cycle irq_in pulse -> same cycle: vec_pc=0x80000004, k0_data=0x00000068, flush/k0_we pulses; next cycle kernel=1; irq_count=1.
- irq_in pulse while ex_redirect=1, then 3 cycles id_ctrl=1, then safe with id_pc=0x84 -> irq_pending held through WAIT; take occurs at first safe cycle with k0_data=0x84.
- Kernel=1, irq_in=1 held, isr_ret=1 -> next cycle kernel=0; following safe cycle retakes the interrupt; irq_count=2.
- undef_inst=1 and irq_in=1 same cycle, id_pc=0x40 -> vec_pc=0x80000008, k0_data=0x44, irq_count unchanged, irq_pending remains 1.
- Assert reset while in KERNEL with irq_pending=1 -> next cycle kernel=0, irq_pending=0; set irq_count=0xFFFF then take irq -> irq_count=0x0000.
